// File: rtl/tnet_rx_deframer.sv
// Aurora RX deframer: turns 3-beat frames into packets and queues them in a FIFO.
// Latency: a packet shows on pkt_valid_o the cycle after its B2 beat if the FIFO was empty.
// Backpressure: the RX stream cannot stall, so a full FIFO drops the packet and counts err_ovf.
// Optional macro TNET_RX_CHK_EN: verify the B2 checksum word and drop bad packets.
module tnet_rx_deframer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             user_clk,
  input  logic             user_aresetn,
  input  logic             channel_up_i,
  input  logic             s_axi_rx_tvalid,
  input  logic [63:0]      s_axi_rx_tdata,
  input  logic             s_axi_rx_tlast,
  output logic             pkt_valid_o,
  input  logic             pkt_ready_i,
  output logic [4:0]       pkt_op_o,
  output logic [47:0]      pkt_time_o,
  output logic [31:0]      pkt_dt1_o,
  output logic [31:0]      pkt_dt2_o,
  output logic [31:0]      pkt_dt3_o,
  output logic [CNT_W-1:0] err_short_o,
  output logic [CNT_W-1:0] err_long_o,
  output logic [CNT_W-1:0] err_ovf_o,
  output logic [CNT_W-1:0] err_chk_o,
  input  logic             clr_err_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PKT_W = 5 + 48 + 3 * 32;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_HDR, ST_D1, ST_D2, ST_DISCARD} state_e;

  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [47:0] time_q, time_d;
  logic [31:0] dt1_q, dt1_d;
  logic [31:0] dt2_q, dt2_d;
  logic        inc_short, inc_long, inc_chk, inc_ovf, pkt_done;
  logic        chk_ok;
  logic        unused_bits;

`ifdef TNET_RX_CHK_EN
  // Checksum folds op/time/data words; compared against the low word of B2.
  assign chk_ok = (s_axi_rx_tdata[31:0] ==
                   (time_q[31:0] ^ {11'b0, op_q, time_q[47:32]} ^ dt1_q ^ dt2_q ^ s_axi_rx_tdata[63:32]));
  assign unused_bits = ^s_axi_rx_tdata[58:48];
`else
  assign chk_ok      = 1'b1;
  assign unused_bits = ^{s_axi_rx_tdata[58:48], s_axi_rx_tdata[31:0], inc_chk};
`endif

  // State and captured header/data words; reset also abandons any partial packet.
  always_ff @(posedge user_clk or negedge user_aresetn) begin
    if (!user_aresetn) begin
      state_q <= ST_HDR;
      op_q    <= '0;
      time_q  <= '0;
      dt1_q   <= '0;
      dt2_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      time_q  <= time_d;
      dt1_q   <= dt1_d;
      dt2_q   <= dt2_d;
    end
  end

  // Frame tracking: beat position decides latch, completion or error; channel-down aborts silently.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    time_d    = time_q;
    dt1_d     = dt1_q;
    dt2_d     = dt2_q;
    inc_short = 1'b0;
    inc_long  = 1'b0;
    inc_chk   = 1'b0;
    pkt_done  = 1'b0;
    if (!channel_up_i) begin
      state_d = ST_HDR;
    end else if (s_axi_rx_tvalid) begin
      case (state_q)
        ST_HDR: begin
          if (s_axi_rx_tlast) begin
            inc_short = 1'b1;
          end else begin
            op_d    = s_axi_rx_tdata[63:59];
            time_d  = s_axi_rx_tdata[47:0];
            state_d = ST_D1;
          end
        end
        ST_D1: begin
          if (s_axi_rx_tlast) begin
            inc_short = 1'b1;
            state_d   = ST_HDR;
          end else begin
            dt1_d   = s_axi_rx_tdata[63:32];
            dt2_d   = s_axi_rx_tdata[31:0];
            state_d = ST_D2;
          end
        end
        ST_D2: begin
          if (s_axi_rx_tlast) begin
            pkt_done = chk_ok;
            inc_chk  = !chk_ok;
            state_d  = ST_HDR;
          end else begin
            inc_long = 1'b1;
            state_d  = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (s_axi_rx_tlast) state_d = ST_HDR;
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic [PKT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PKT_W-1:0] head_dat;
  logic             pop, push, full;

  assign pkt_valid_o = (cnt_q != '0);
  assign pop         = pkt_valid_o & pkt_ready_i;
  assign full        = (cnt_q == DEPTH_C);
  // A pop in the same cycle frees the slot, so a full FIFO can still take the packet.
  assign push        = pkt_done & (!full | pop);
  assign inc_ovf     = pkt_done & full & !pop;
  assign head_dat    = mem_q[rd_ptr_q];
  assign {pkt_op_o, pkt_time_o, pkt_dt1_o, pkt_dt2_o, pkt_dt3_o} = pkt_valid_o ? head_dat : '0;

  // Packet storage; B2's high word is written straight from the bus.
  always_ff @(posedge user_clk) begin
    if (push) mem_q[wr_ptr_q] <= {op_q, time_q, dt1_q, dt2_q, s_axi_rx_tdata[63:32]};
  end

  // FIFO pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge user_clk or negedge user_aresetn) begin
    if (!user_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c, input logic inc,
                                                input logic clr);
    if (clr) return '0;
    if (inc && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  // Saturating error counters; a clear wins over a same-cycle increment.
  always_ff @(posedge user_clk or negedge user_aresetn) begin
    if (!user_aresetn) begin
      err_short_o <= '0;
      err_long_o  <= '0;
      err_ovf_o   <= '0;
    end else begin
      err_short_o <= cnt_next(err_short_o, inc_short, clr_err_i);
      err_long_o  <= cnt_next(err_long_o, inc_long, clr_err_i);
      err_ovf_o   <= cnt_next(err_ovf_o, inc_ovf, clr_err_i);
    end
  end

`ifdef TNET_RX_CHK_EN
  // Checksum error counter, same saturate/clear rules as the others.
  always_ff @(posedge user_clk or negedge user_aresetn) begin
    if (!user_aresetn) err_chk_o <= '0;
    else               err_chk_o <= cnt_next(err_chk_o, inc_chk, clr_err_i);
  end
`else
  assign err_chk_o = '0;
`endif

endmodule

// File: doc/tnet_rx_deframer.md
TNET_RX_DEFRAMER -- requirements
Module: tnet_rx_deframer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, packet FIFO depth in packets; power of two, 2..16.
REQ-002 Parameter CNT_W, default 8, width of each error counter.
REQ-003 Port user_clk, input, 1: sole clock, the Aurora RX user clock.
REQ-004 Port user_aresetn, input, 1: asynchronous, active-low reset.
REQ-005 Port channel_up_i, input, 1: Aurora RX channel-up.
REQ-006 Ports s_axi_rx_tvalid/tdata[63:0]/tlast, input: Aurora RX stream with no tready; a beat is taken whenever tvalid=1.
REQ-007 Ports pkt_valid_o (output, 1) and pkt_ready_i (input, 1): packet handshake; transfer when both are 1.
REQ-008 Ports pkt_op_o[4:0], pkt_time_o[47:0], pkt_dt1_o, pkt_dt2_o, pkt_dt3_o[31:0], output: fields of the head packet.
REQ-009 Ports err_short_o, err_long_o, err_ovf_o, err_chk_o [CNT_W-1:0], output: error counters.
REQ-010 Port clr_err_i, input, 1: synchronous clear of all error counters.

Function
REQ-011 A packet SHALL be 3 beats: B0 = {op[63:59], rsvd[58:48], time[47:0]}, B1 = {dt1[63:32], dt2[31:0]}, B2 = {dt3[63:32], chk[31:0]}; tlast SHALL be set on B2 only.
REQ-012 The FSM SHALL have states HDR, D1, D2, DISCARD; reset state is HDR.
REQ-013 In HDR: a beat with tlast=1 SHALL increment err_short and the FSM stays in HDR; otherwise B0 is latched and the FSM moves to D1.
REQ-014 In D1: tlast=1 SHALL increment err_short and return to HDR; otherwise B1 is latched and the FSM moves to D2.
REQ-015 In D2: tlast=1 SHALL complete the packet and return to HDR; tlast=0 SHALL increment err_long, discard the packet and move to DISCARD.
REQ-016 In DISCARD: beats SHALL be dropped until a beat with tlast=1, then the FSM returns to HDR.
REQ-017 A completed packet SHALL be written into the FIFO on the B2 clock edge; pkt_valid_o SHALL rise the next cycle when the FIFO was empty (1-cycle latency).
REQ-018 FIFO output fields SHALL be stable while pkt_valid_o=1 and pkt_ready_i=0; FIFO order SHALL be first-in, first-out.
REQ-019 A write SHALL be accepted when count < FIFO_DEPTH, or when count = FIFO_DEPTH and a pop happens in the same cycle.
REQ-020 Otherwise the completed packet SHALL be dropped and err_ovf incremented; FIFO contents are unchanged.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 channel_up_i=0 SHALL force the FSM to HDR and discard the partial packet without counting an error; FIFO contents are kept.
REQ-023 Error counters SHALL saturate at all-ones.
REQ-024 clr_err_i SHALL zero the counters; an increment in the same cycle as clr_err_i is lost.
REQ-025 Multiple counters MAY increment in the same cycle.

Reset
REQ-026 On user_aresetn=0, asynchronously: FSM to HDR, FIFO empty (pkt_valid_o=0), pointers 0, all counters 0, pkt_* fields 0.
REQ-027 Reset mid-packet SHALL discard the partial packet.
REQ-028 After release, the first beat SHALL be treated as B0.

Configuration
REQ-029 Macro TNET_RX_CHK_EN defined: chk SHALL equal time[31:0]^{11'b0,op,time[47:32]}^dt1^dt2^dt3.
REQ-030 With TNET_RX_CHK_EN, a chk mismatch SHALL drop the packet, increment err_chk and return the FSM to HDR.
REQ-031 Macro TNET_RX_CHK_EN undefined: chk SHALL be ignored, err_chk_o SHALL be tied to 0, and no checksum logic is built.

Verification
REQ-032 Valid 3-beat packet (op=5'h3, time=48'h1234, dt1=1, dt2=2, dt3=3, correct chk), pkt_ready_i=1 -> pkt_valid_o high exactly 1 cycle after B2 with matching fields; all counters 0.
REQ-033 2-beat packet with tlast on beat 2, then a valid packet -> err_short=1; the second packet is delivered intact.
REQ-034 4-beat packet (tlast on beat 4), then a valid packet -> err_long=1; the 4-beat packet is not delivered and the valid packet is delivered.
REQ-035 pkt_ready_i=0, 6 valid packets with FIFO_DEPTH=4 -> 4 stored, err_ovf=2; then pkt_ready_i=1 -> the first 4 packets pop in order.
REQ-036 channel_up_i drops after B1, then a valid packet -> no error counted; the valid packet is delivered.
REQ-037 With TNET_RX_CHK_EN, flip chk bit 0 -> packet dropped, err_chk=1; without the macro -> packet delivered, err_chk_o=0.
